// File: rtl/cpu_hazard_ctrl.sv
// Scoreboard-based issue gating for the CPU pipeline: per-register pending-write
// counters drive RAW/WAW stalls, and a two-state FSM holds issue behind an unresolved jump/branch.
module cpu_hazard_ctrl #(
  parameter int unsigned NUM_REGS           = 16,
  parameter int unsigned REG_SEL_W          = $clog2(NUM_REGS),
  parameter int unsigned MAX_INFLIGHT       = 3,
  parameter int unsigned ZERO_REG_HARDWIRED = 0,
  parameter int unsigned STAT_W             = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_SEL_W-1:0] id_src1,
  input  logic [REG_SEL_W-1:0] id_src2,
  input  logic                 id_src1_used,
  input  logic                 id_src2_used,
  input  logic                 id_wrt_en,
  input  logic [REG_SEL_W-1:0] id_wrt_reg,
  input  logic                 id_is_jb,
  input  logic                 br_resolve,
  input  logic                 br_taken,
  input  logic                 wb_valid,
  input  logic                 wb_wrt_en,
  input  logic [REG_SEL_W-1:0] wb_wrt_reg,
  output logic                 issue,
  output logic                 stall,
  output logic                 flush,
  output logic                 jb_pending,
  output logic [NUM_REGS-1:0]  busy_regs,
  output logic [STAT_W-1:0]    stall_cnt,
  output logic                 err
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } jb_state_e;

  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  jb_state_e           r_jb_state;
  logic                r_flush;
  logic [STAT_W-1:0]   r_stall_cnt;
  logic                r_err;

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_full;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic                w_raw;
  logic                w_sat;
  logic                w_stall;
  logic                w_issue;
  logic                w_underflow;
  logic                w_stray_resolve;

  // Per-register occupancy; a hardwired r0 is never reported busy or full.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
      w_full[i] = (r_cnt[i] == CNT_MAX);
    end
    if (ZERO_REG_HARDWIRED != 0) begin
      w_busy[0] = 1'b0;
      w_full[0] = 1'b0;
    end
  end

  assign w_raw   = (id_src1_used & w_busy[id_src1]) | (id_src2_used & w_busy[id_src2]);
  assign w_sat   = id_wrt_en & w_full[id_wrt_reg];
  assign w_stall = id_valid & (w_raw | w_sat | (r_jb_state == ST_WAIT));
  assign w_issue = id_valid & ~w_stall;

  // One-hot increment/decrement requests; a retire never bypasses into the same cycle's hazard check.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issue && id_wrt_en) begin
      w_inc[id_wrt_reg] = 1'b1;
    end
    if (wb_valid && wb_wrt_en) begin
      w_dec[wb_wrt_reg] = 1'b1;
    end
    if (ZERO_REG_HARDWIRED != 0) begin
      w_inc[0] = 1'b0;
      w_dec[0] = 1'b0;
    end
  end

  assign w_underflow     = |(w_dec & ~w_inc & ~w_busy);
  assign w_stray_resolve = br_resolve & (r_jb_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Jump/branch tracking; flush is a one-cycle pulse on a taken resolution.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_jb_state <= ST_IDLE;
      r_flush    <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_jb_state)
        ST_IDLE: begin
          if (w_issue && id_is_jb) begin
            r_jb_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (br_resolve) begin
            r_jb_state <= ST_IDLE;
            r_flush    <= br_taken;
          end
        end
        default: r_jb_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      end
      r_err <= r_err | w_underflow | w_stray_resolve;
    end
  end

  assign issue      = w_issue;
  assign stall      = w_stall;
  assign flush      = r_flush;
  assign jb_pending = (r_jb_state == ST_WAIT);
  assign busy_regs  = w_busy;
  assign stall_cnt  = r_stall_cnt;
  assign err        = r_err;

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Bench for cpu_hazard_ctrl: per-scenario stimulus tables with expected outputs
// queued at drive time and compared after the inputs settle.
module tb_cpu_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [3:0] s1;
    logic       u1;
    logic [3:0] s2;
    logic       u2;
    logic       we;
    logic [3:0] wr;
    logic       jb;
    logic       brr;
    logic       brt;
    logic       wbv;
    logic [3:0] wbr;
  } stim_t;

  typedef struct packed {
    logic        issue;
    logic        stall;
    logic        flush;
    logic        jbp;
    logic        err;
    logic [15:0] busy;
    logic [31:0] scnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_src1_used, id_src2_used, id_wrt_en, id_is_jb;
  logic [3:0]  id_src1, id_src2, id_wrt_reg, wb_wrt_reg;
  logic        br_resolve, br_taken, wb_valid, wb_wrt_en;

  logic        issue, stall, flush, jb_pending, err;
  logic [15:0] busy_regs;
  logic [31:0] stall_cnt;
  logic        z_issue, z_stall, z_flush, z_jb_pending, z_err;
  logic [15:0] z_busy_regs;
  logic [31:0] z_stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  cpu_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_wrt_en(id_wrt_en),
    .id_wrt_reg(id_wrt_reg), .id_is_jb(id_is_jb), .br_resolve(br_resolve), .br_taken(br_taken),
    .wb_valid(wb_valid), .wb_wrt_en(wb_wrt_en), .wb_wrt_reg(wb_wrt_reg),
    .issue(issue), .stall(stall), .flush(flush), .jb_pending(jb_pending),
    .busy_regs(busy_regs), .stall_cnt(stall_cnt), .err(err)
  );

  cpu_hazard_ctrl #(.ZERO_REG_HARDWIRED(1)) dut_z (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_wrt_en(id_wrt_en),
    .id_wrt_reg(id_wrt_reg), .id_is_jb(id_is_jb), .br_resolve(br_resolve), .br_taken(br_taken),
    .wb_valid(wb_valid), .wb_wrt_en(wb_wrt_en), .wb_wrt_reg(wb_wrt_reg),
    .issue(z_issue), .stall(z_stall), .flush(z_flush), .jb_pending(z_jb_pending),
    .busy_regs(z_busy_regs), .stall_cnt(z_stall_cnt), .err(z_err)
  );

  function automatic stim_t s_nop();
    return '0;
  endfunction

  function automatic stim_t s_id(int s1, int u1, int s2, int u2, int we, int wr, int jb);
    stim_t s = '0;
    s.v  = 1'b1;
    s.s1 = 4'(s1);
    s.u1 = 1'(u1);
    s.s2 = 4'(s2);
    s.u2 = 1'(u2);
    s.we = 1'(we);
    s.wr = 4'(wr);
    s.jb = 1'(jb);
    return s;
  endfunction

  function automatic stim_t s_wb(stim_t b, int r);
    stim_t s = b;
    s.wbv = 1'b1;
    s.wbr = 4'(r);
    return s;
  endfunction

  function automatic stim_t s_br(stim_t b, int taken);
    stim_t s = b;
    s.brr = 1'b1;
    s.brt = 1'(taken);
    return s;
  endfunction

  function automatic exp_t e_mk(int iss, int stl, int fl, int jbp, int er, int busy, int sc);
    return {1'(iss), 1'(stl), 1'(fl), 1'(jbp), 1'(er), 16'(busy), 32'(sc)};
  endfunction

  function automatic exp_t grab0();
    return {issue, stall, flush, jb_pending, err, busy_regs, stall_cnt};
  endfunction

  function automatic exp_t grab_z();
    return {z_issue, z_stall, z_flush, z_jb_pending, z_err, z_busy_regs, z_stall_cnt};
  endfunction

  function automatic string fmt(exp_t x);
    return $sformatf("issue=%0b stall=%0b flush=%0b jbp=%0b err=%0b busy=%04h scnt=%0d",
                     x.issue, x.stall, x.flush, x.jbp, x.err, x.busy, x.scnt);
  endfunction

  // Apply one cycle of stimulus at the falling edge and queue what it must produce.
  task automatic drive(input stim_t s, input exp_t e);
    @(negedge clk);
    rst          = s.rst;
    id_valid     = s.v;
    id_src1      = s.s1;
    id_src1_used = s.u1;
    id_src2      = s.s2;
    id_src2_used = s.u2;
    id_wrt_en    = s.we;
    id_wrt_reg   = s.wr;
    id_is_jb     = s.jb;
    br_resolve   = s.brr;
    br_taken     = s.brt;
    wb_valid     = s.wbv;
    wb_wrt_en    = s.wbv;
    wb_wrt_reg   = s.wbr;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    stim_t s = '0;
    s.rst = 1'b1;
    @(negedge clk);
    rst = s.rst; id_valid = 1'b0; id_wrt_en = 1'b0; br_resolve = 1'b0; wb_valid = 1'b0;
    wb_wrt_en = 1'b0; id_src1_used = 1'b0; id_src2_used = 1'b0; id_is_jb = 1'b0;
  endtask

  task automatic test_reset();
    stim_t st[$]; exp_t ex[$]; exp_t e, a;
    do_reset();
    st.push_back(s_nop());                    ex.push_back(e_mk(0,0,0,0,0,16'h0000,0));
    st.push_back(s_id(2,1,9,1,1,6,0));        ex.push_back(e_mk(1,0,0,0,0,16'h0000,0));
    st.push_back(s_nop());                    ex.push_back(e_mk(0,0,0,0,0,16'h0040,0));
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      #1;
      e = sb_q.pop_front(); a = grab0(); n_vec++;
      if (a !== e) begin n_err++; $display("FAIL reset[%0d] got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_raw();
    stim_t st[$]; exp_t ex[$]; exp_t e, a; stim_t t;
    do_reset();
    st.push_back(s_id(0,0,0,0,1,3,0));        ex.push_back(e_mk(1,0,0,0,0,16'h0000,0));
    st.push_back(s_id(3,1,0,0,0,0,0));        ex.push_back(e_mk(0,1,0,0,0,16'h0008,0));
    t = s_id(3,1,0,0,0,0,0); t.v = 1'b0;
    st.push_back(t);                          ex.push_back(e_mk(0,0,0,0,0,16'h0008,1));
    st.push_back(s_id(0,0,3,1,0,0,0));        ex.push_back(e_mk(0,1,0,0,0,16'h0008,1));
    st.push_back(s_wb(s_id(0,0,3,1,0,0,0),3)); ex.push_back(e_mk(0,1,0,0,0,16'h0008,2));
    st.push_back(s_id(3,1,0,0,0,0,0));        ex.push_back(e_mk(1,0,0,0,0,16'h0000,3));
    st.push_back(s_nop());                    ex.push_back(e_mk(0,0,0,0,0,16'h0000,3));
    st.push_back(s_id(0,0,0,0,1,3,0));        ex.push_back(e_mk(1,0,0,0,0,16'h0000,3));
    st.push_back(s_id(3,0,0,1,0,0,0));        ex.push_back(e_mk(1,0,0,0,0,16'h0008,3));
    st.push_back(s_nop());                    ex.push_back(e_mk(0,0,0,0,0,16'h0008,3));
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      #1;
      e = sb_q.pop_front(); a = grab0(); n_vec++;
      if (a !== e) begin n_err++; $display("FAIL raw[%0d] got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_waw_sat();
    stim_t st[$]; exp_t ex[$]; exp_t e, a; stim_t w5;
    do_reset();
    w5 = s_id(0,0,0,0,1,5,0);
    st.push_back(w5);          ex.push_back(e_mk(1,0,0,0,0,16'h0000,0));
    st.push_back(w5);          ex.push_back(e_mk(1,0,0,0,0,16'h0020,0));
    st.push_back(w5);          ex.push_back(e_mk(1,0,0,0,0,16'h0020,0));
    st.push_back(w5);          ex.push_back(e_mk(0,1,0,0,0,16'h0020,0));
    st.push_back(s_wb(w5,5));  ex.push_back(e_mk(0,1,0,0,0,16'h0020,1));
    st.push_back(w5);          ex.push_back(e_mk(1,0,0,0,0,16'h0020,2));
    st.push_back(w5);          ex.push_back(e_mk(0,1,0,0,0,16'h0020,2));
    st.push_back(s_nop());     ex.push_back(e_mk(0,0,0,0,0,16'h0020,3));
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      #1;
      e = sb_q.pop_front(); a = grab0(); n_vec++;
      if (a !== e) begin n_err++; $display("FAIL waw_sat[%0d] got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_branch();
    stim_t st[$]; exp_t ex[$]; exp_t e, a; stim_t jb, pl;
    do_reset();
    jb = s_id(0,0,0,0,0,0,1);
    pl = s_id(0,0,0,0,0,0,0);
    st.push_back(jb);           ex.push_back(e_mk(1,0,0,0,0,0,0));
    st.push_back(pl);           ex.push_back(e_mk(0,1,0,1,0,0,0));
    st.push_back(s_br(pl,1));   ex.push_back(e_mk(0,1,0,1,0,0,1));
    st.push_back(pl);           ex.push_back(e_mk(1,0,1,0,0,0,2));
    st.push_back(s_nop());      ex.push_back(e_mk(0,0,0,0,0,0,2));
    st.push_back(jb);           ex.push_back(e_mk(1,0,0,0,0,0,2));
    st.push_back(pl);           ex.push_back(e_mk(0,1,0,1,0,0,2));
    st.push_back(s_br(pl,0));   ex.push_back(e_mk(0,1,0,1,0,0,3));
    st.push_back(pl);           ex.push_back(e_mk(1,0,0,0,0,0,4));
    st.push_back(s_nop());      ex.push_back(e_mk(0,0,0,0,0,0,4));
    st.push_back(jb);           ex.push_back(e_mk(1,0,0,0,0,0,4));
    st.push_back(s_br(jb,1));   ex.push_back(e_mk(0,1,0,1,0,0,4));
    st.push_back(jb);           ex.push_back(e_mk(1,0,1,0,0,0,5));
    st.push_back(s_nop());      ex.push_back(e_mk(0,0,0,1,0,0,5));
    st.push_back(s_br(s_nop(),0)); ex.push_back(e_mk(0,0,0,1,0,0,5));
    st.push_back(s_nop());      ex.push_back(e_mk(0,0,0,0,0,0,5));
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      #1;
      e = sb_q.pop_front(); a = grab0(); n_vec++;
      if (a !== e) begin n_err++; $display("FAIL branch[%0d] got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$]; exp_t ex[$]; exp_t e, a;
    do_reset();
    st.push_back(s_id(0,0,0,0,1,7,0));          ex.push_back(e_mk(1,0,0,0,0,16'h0000,0));
    st.push_back(s_wb(s_id(0,0,0,0,1,7,0),7));  ex.push_back(e_mk(1,0,0,0,0,16'h0080,0));
    st.push_back(s_nop());                      ex.push_back(e_mk(0,0,0,0,0,16'h0080,0));
    st.push_back(s_wb(s_nop(),7));              ex.push_back(e_mk(0,0,0,0,0,16'h0080,0));
    st.push_back(s_nop());                      ex.push_back(e_mk(0,0,0,0,0,16'h0000,0));
    st.push_back(s_wb(s_nop(),2));              ex.push_back(e_mk(0,0,0,0,0,16'h0000,0));
    st.push_back(s_nop());                      ex.push_back(e_mk(0,0,0,0,1,16'h0000,0));
    st.push_back(s_id(0,0,0,0,0,0,0));          ex.push_back(e_mk(1,0,0,0,1,16'h0000,0));
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      #1;
      e = sb_q.pop_front(); a = grab0(); n_vec++;
      if (a !== e) begin n_err++; $display("FAIL back_to_back[%0d] got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_zero_reg();
    stim_t st[$]; exp_t ex[$]; exp_t e, a;
    do_reset();
    st.push_back(s_id(0,1,0,1,1,0,0));   ex.push_back(e_mk(1,0,0,0,0,0,0));
    st.push_back(s_id(0,1,0,1,1,0,0));   ex.push_back(e_mk(1,0,0,0,0,0,0));
    st.push_back(s_id(0,1,0,1,1,0,0));   ex.push_back(e_mk(1,0,0,0,0,0,0));
    st.push_back(s_id(0,1,0,0,1,0,0));   ex.push_back(e_mk(1,0,0,0,0,0,0));
    st.push_back(s_br(s_nop(),1));       ex.push_back(e_mk(0,0,0,0,0,0,0));
    st.push_back(s_nop());               ex.push_back(e_mk(0,0,0,0,1,0,0));
    st.push_back(s_id(0,1,0,1,1,0,0));   ex.push_back(e_mk(1,0,0,0,1,0,0));
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      #1;
      e = sb_q.pop_front(); a = grab_z(); n_vec++;
      if (a !== e) begin n_err++; $display("FAIL zero_reg[%0d] got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$]; exp_t ex[$]; exp_t e, a; stim_t pl, t;
    do_reset();
    pl = s_id(0,0,0,0,0,0,0);
    st.push_back(s_br(s_id(0,0,0,0,1,1,0),0)); ex.push_back(e_mk(1,0,0,0,0,16'h0000,0));
    st.push_back(s_id(0,0,0,0,1,4,0));         ex.push_back(e_mk(1,0,0,0,1,16'h0002,0));
    st.push_back(s_id(0,0,0,0,0,0,1));         ex.push_back(e_mk(1,0,0,0,1,16'h0012,0));
    for (int k = 0; k < 9; k++) begin
      st.push_back(pl);                        ex.push_back(e_mk(0,1,0,1,1,16'h0012,k));
    end
    t = pl; t.rst = 1'b1;
    st.push_back(t);                           ex.push_back(e_mk(0,1,0,1,1,16'h0012,9));
    st.push_back(s_id(1,1,0,0,1,4,0));         ex.push_back(e_mk(1,0,0,0,0,16'h0000,0));
    st.push_back(s_nop());                     ex.push_back(e_mk(0,0,0,0,0,16'h0010,0));
    foreach (st[i]) begin
      drive(st[i], ex[i]);
      #1;
      e = sb_q.pop_front(); a = grab0(); n_vec++;
      if (a !== e) begin n_err++; $display("FAIL reset_mid[%0d] got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_src1_used = 1'b0;
    id_src2_used = 1'b0; id_wrt_en = 1'b0; id_wrt_reg = '0; id_is_jb = 1'b0;
    br_resolve = 1'b0; br_taken = 1'b0; wb_valid = 1'b0; wb_wrt_en = 1'b0; wb_wrt_reg = '0;
    test_reset();
    test_raw();
    test_waw_sat();
    test_branch();
    test_back_to_back();
    test_zero_reg();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_hazard_ctrl.md
Name: cpu_hazard_ctrl

Overview:
- Parametrised scoreboard-based hazard and stall controller for the CPU pipeline.
- Replaces fixed per-stage write-register comparison with per-register pending-write counters, so it scales to any pipeline depth and register count.
- Gates issue from ID into ID/EX on RAW hazards, scoreboard saturation and unresolved jumps/branches.
- Issues a one-cycle IF/ID flush on taken branches, and maintains stall statistics and an error flag.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked.
- REG_SEL_W, 4, register select width; $clog2(NUM_REGS).
- MAX_INFLIGHT, 3, maximum outstanding writes to one register; must be ≥ 1.
- ZERO_REG_HARDWIRED, 0, 1 = register 0 is never tracked and never causes a stall.
- STAT_W, 32, stall counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  valid instruction in ID
- id_src1  in  REG_SEL_W  source register 1 (Rs)
- id_src2  in  REG_SEL_W  source register 2 (Rt, or Rd for stores)
- id_src1_used  in  1  src1 is read
- id_src2_used  in  1  src2 is read
- id_wrt_en  in  1  ID instruction writes the register file
- id_wrt_reg  in  REG_SEL_W  ID destination register
- id_is_jb  in  1  ID instruction is a jump or branch
- br_resolve  in  1  EX resolves the outstanding jump/branch this cycle
- br_taken  in  1  resolution outcome, qualified by br_resolve
- wb_valid  in  1  instruction retiring in WB
- wb_wrt_en  in  1  retiring instruction writes the register file
- wb_wrt_reg  in  REG_SEL_W  retiring destination register
- issue  out  1  ID instruction advances this cycle
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- flush  out  1  invalidate IF/ID contents; registered
- jb_pending  out  1  jump/branch issued, not yet resolved
- busy_regs  out  NUM_REGS  bit i = cnt[i] != 0
- stall_cnt  out  STAT_W  cycles with stall=1
- err  out  1  sticky protocol error

Behaviour:
- **State:**
  - cnt[i] for each register: width $clog2(MAX_INFLIGHT+1).
  - jb_pending, flush, stall_cnt, err.
- **Reset:** all cnt = 0, jb_pending = 0, flush = 0, stall_cnt = 0, err = 0. A reset in the middle of operation discards every pending write and any outstanding branch immediately; outputs take reset values in the cycle after the reset edge.
- **Combinational stall terms** (all use registered state):
  - raw = (id_src1_used & cnt[id_src1] != 0) | (id_src2_used & cnt[id_src2] != 0).
  - sat = id_wrt_en & cnt[id_wrt_reg] == MAX_INFLIGHT.
- **Stall and issue:**
  - stall = id_valid & (raw | sat | jb_pending).
  - issue = id_valid & ~stall.
  - id_valid = 0 → stall = 0, issue = 0.
- **Register 0:** when ZERO_REG_HARDWIRED = 1, register 0 is excluded from raw and sat, cnt[0] is never incremented, and busy_regs[0] = 0.
- **Retire in the same cycle does not bypass:** a retire that clears a source's counter in cycle N still stalls in cycle N; issue occurs in N+1. This is a one-cycle conservative penalty to keep RF write-then-read timing safe.
- **Counter update, per register r, each cycle:**
  - inc = issue & id_wrt_en & id_wrt_reg == r.
  - dec = wb_valid & wb_wrt_en & wb_wrt_reg == r.
  - inc & dec: unchanged.
  - inc only: +1. Saturation cannot be exceeded because sat blocks issue.
  - dec only with cnt[r] == 0: unchanged, and err <= 1 (underflow).
- **Jump/branch FSM:**
  - States are IDLE (jb_pending = 0) and WAIT (jb_pending = 1).
  - IDLE → WAIT on issue & id_is_jb.
  - WAIT → IDLE on br_resolve; flush <= br_taken for exactly one cycle, otherwise flush <= 0.
  - In WAIT, br_resolve and a new jump/branch in ID in the same cycle: the new one stays stalled that cycle (jb_pending still 1), issues the next cycle if no other hazard.
  - br_resolve in IDLE: ignored, err <= 1.
  - flush does not affect cnt (the flushed instruction never issued).
- **Statistics and error:**
  - stall_cnt increments when stall = 1 and saturates at all ones.
  - err is sticky until rst.
- **Latency:** issue and stall are combinational from inputs and state. Counters, jb_pending and flush update on the clock edge.

Test Plan:
- **RAW:**
  - Stimulus: issue write r3 (cycle 0); next cycle, ID reads src1 = r3 with src1_used = 1.
  - Required: stall = 1 until the cycle after wb retire of r3, then issue = 1; stall_cnt equals the number of stalled cycles; busy_regs[3] falls the cycle after retire.
- **WAW saturation** (MAX_INFLIGHT = 3):
  - Stimulus: issue 3 writes to r5 with no retire; present a 4th.
  - Required: stall = 1 (sat), cnt[5] = 3; one retire of r5 → 4th issues next cycle, cnt[5] stays 3.
- **Branch taken / not taken:**
  - Stimulus: jump/branch issues; following instruction held 2 cycles; br_resolve = 1, br_taken = 1.
  - Required: flush = 1 for exactly one cycle and jb_pending = 0 after; repeating with br_taken = 0 gives flush = 0.
- **Simultaneous issue and retire to r7** (cnt[7] = 1):
  - Required: cnt[7] stays 1; underflow retire to r2 with cnt = 0 → err = 1 and stays set.
- **ZERO_REG_HARDWIRED = 1:**
  - Stimulus: writes and reads of r0 back-to-back.
  - Required: never stall, busy_regs[0] = 0; stray br_resolve in IDLE → err = 1.
- **Reset mid-operation:**
  - Stimulus: r1 and r4 busy, jb_pending = 1, stall_cnt = 9; assert rst for one cycle.
  - Required: all cnt = 0, busy_regs = 0, jb_pending = 0, flush = 0, stall_cnt = 0, err = 0; the next id_valid instruction issues immediately.
